// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle main control FSM and the MIPS datapath.
// The FSM side takes the master modport; the datapath/IR side takes the slave modport.
interface multicycle_control_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic       IllegalOp;
  logic [3:0] State;

  modport master (
    input  Opcode, Funct, Zero, MemReady,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp, State
  );

  modport slave (
    output Opcode, Funct, Zero, MemReady,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp, State
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM: sequences fetch, decode, execute, memory and
// write-back, driving datapath selects, write enables and the 3-bit ALUOp.
module multicycle_control (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JAL       = 4'd12,
    S_JR        = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_RTYPE  = 3'b111;
  localparam logic [2:0] ALU_ADD    = 3'b110;
  localparam logic [2:0] ALU_OR     = 3'b101;
  localparam logic [2:0] ALU_AND    = 3'b011;
  localparam logic [2:0] ALU_LUI    = 3'b001;
  localparam logic [2:0] ALU_ADDR   = 3'b010;
  localparam logic [2:0] ALU_BRANCH = 3'b100;

  state_t     r_state;
  state_t     w_next_state;
  logic       w_pcwrite;
  logic       w_iord;
  logic       w_memread;
  logic       w_memwrite;
  logic       w_irwrite;
  logic [1:0] w_regdst;
  logic [1:0] w_memtoreg;
  logic       w_regwrite;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [2:0] w_aluop;
  logic [1:0] w_pcsource;
  logic       w_illegal;

  // State register; reset abandons whatever instruction is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and per-state datapath control decode.
  always_comb begin
    w_next_state = S_FETCH;
    w_pcwrite    = 1'b0;
    w_iord       = 1'b0;
    w_memread    = 1'b0;
    w_memwrite   = 1'b0;
    w_irwrite    = 1'b0;
    w_regdst     = 2'b00;
    w_memtoreg   = 2'b00;
    w_regwrite   = 1'b0;
    w_alusrca    = 1'b0;
    w_alusrcb    = 2'b00;
    w_aluop      = 3'b000;
    w_pcsource   = 2'b00;
    w_illegal    = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_memread = 1'b1;
        w_alusrcb = 2'b01;
        w_aluop   = ALU_ADD;
        if (bus.MemReady) begin
          w_irwrite    = 1'b1;
          w_pcwrite    = 1'b1;
          w_next_state = S_DECODE;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        w_alusrcb = 2'b11;
        w_aluop   = ALU_ADD;
        case (bus.Opcode)
          OP_RTYPE: begin
            if (bus.Funct == FN_JR) begin
              w_next_state = S_JR;
            end else begin
              w_next_state = S_R_EXEC;
            end
          end
          OP_LW, OP_SW:                     w_next_state = S_MEM_ADDR;
          OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: w_next_state = S_I_EXEC;
          OP_BEQ, OP_BNE:                   w_next_state = S_BRANCH;
          OP_J:                             w_next_state = S_JUMP;
          OP_JAL:                           w_next_state = S_JAL;
          default: begin
            w_illegal    = 1'b1;
            w_next_state = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_aluop   = ALU_ADDR;
        if (bus.Opcode == OP_SW) begin
          w_next_state = S_MEM_WRITE;
        end else begin
          w_next_state = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        w_memread = 1'b1;
        w_iord    = 1'b1;
        if (bus.MemReady) begin
          w_next_state = S_MEM_WB;
        end else begin
          w_next_state = S_MEM_READ;
        end
      end
      S_MEM_WB: begin
        w_regwrite   = 1'b1;
        w_memtoreg   = 2'b01;
        w_regdst     = 2'b00;
        w_next_state = S_FETCH;
      end
      S_MEM_WRITE: begin
        w_memwrite = 1'b1;
        w_iord     = 1'b1;
        if (bus.MemReady) begin
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_MEM_WRITE;
        end
      end
      S_R_EXEC: begin
        w_alusrca    = 1'b1;
        w_alusrcb    = 2'b00;
        w_aluop      = ALU_RTYPE;
        w_next_state = S_R_WB;
      end
      S_R_WB: begin
        w_regwrite   = 1'b1;
        w_regdst     = 2'b01;
        w_memtoreg   = 2'b00;
        w_next_state = S_FETCH;
      end
      S_I_EXEC: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        case (bus.Opcode)
          OP_ORI:  w_aluop = ALU_OR;
          OP_ANDI: w_aluop = ALU_AND;
          OP_LUI:  w_aluop = ALU_LUI;
          default: w_aluop = ALU_ADD;
        endcase
        w_next_state = S_I_WB;
      end
      S_I_WB: begin
        w_regwrite   = 1'b1;
        w_regdst     = 2'b00;
        w_memtoreg   = 2'b00;
        w_next_state = S_FETCH;
      end
      S_BRANCH: begin
        w_alusrca  = 1'b1;
        w_alusrcb  = 2'b00;
        w_aluop    = ALU_BRANCH;
        w_pcsource = 2'b01;
        if (bus.Opcode == OP_BNE) begin
          w_pcwrite = ~bus.Zero;
        end else begin
          w_pcwrite = bus.Zero;
        end
        w_next_state = S_FETCH;
      end
      S_JUMP: begin
        w_pcsource   = 2'b10;
        w_pcwrite    = 1'b1;
        w_next_state = S_FETCH;
      end
      S_JAL: begin
        // PC already holds PC+4 from fetch, so $31 gets the return address.
        w_pcsource   = 2'b10;
        w_pcwrite    = 1'b1;
        w_regwrite   = 1'b1;
        w_regdst     = 2'b10;
        w_memtoreg   = 2'b10;
        w_next_state = S_FETCH;
      end
      S_JR: begin
        w_aluop      = ALU_RTYPE;
        w_pcsource   = 2'b11;
        w_pcwrite    = 1'b1;
        w_next_state = S_FETCH;
      end
      default: begin
        w_next_state = S_FETCH;
      end
    endcase
  end

  // Write enables and requests are suppressed while reset is high so no
  // partial write can escape from an abandoned instruction.
  assign bus.PCWrite   = w_pcwrite  & ~reset;
  assign bus.IRWrite   = w_irwrite  & ~reset;
  assign bus.RegWrite  = w_regwrite & ~reset;
  assign bus.MemWrite  = w_memwrite & ~reset;
  assign bus.MemRead   = w_memread  & ~reset;
  assign bus.IllegalOp = w_illegal  & ~reset;
  assign bus.IorD      = w_iord;
  assign bus.RegDst    = w_regdst;
  assign bus.MemtoReg  = w_memtoreg;
  assign bus.ALUSrcA   = w_alusrca;
  assign bus.ALUSrcB   = w_alusrcb;
  assign bus.ALUOp     = w_aluop;
  assign bus.PCSource  = w_pcsource;
  assign bus.State     = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected state and
// control vectors go into a scoreboard queue as stimulus is driven and are
// popped and compared at the following falling edge.
module tb_multicycle_control;

  logic clk;
  logic reset;

  multicycle_control_if u_if ();

  multicycle_control u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.master)
  );

  typedef struct {
    string      tag;
    logic [3:0] state;
    logic [18:0] vec;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks;
  int   n_fail;

  logic [18:0] w_obs;
  assign w_obs = {u_if.PCWrite, u_if.IorD, u_if.MemRead, u_if.MemWrite, u_if.IRWrite,
                  u_if.RegDst, u_if.MemtoReg, u_if.RegWrite, u_if.ALUSrcA,
                  u_if.ALUSrcB, u_if.ALUOp, u_if.PCSource, u_if.IllegalOp};

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Run-time bound so the bench never hangs.
  initial begin
    #100000;
    $display("FAIL watchdog: run still active, required finish before time 100000");
    $fatal(1, "watchdog expired");
  end

  // Pack a control vector in the same bit order as w_obs.
  function automatic logic [18:0] ov(input logic pcw, input logic iord, input logic mr,
                                     input logic mw, input logic irw, input logic [1:0] rd,
                                     input logic [1:0] m2r, input logic rw, input logic sa,
                                     input logic [1:0] sb, input logic [2:0] op,
                                     input logic [1:0] ps, input logic ill);
    return {pcw, iord, mr, mw, irw, rd, m2r, rw, sa, sb, op, ps, ill};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, record the expectation, compare at negedge.
  task automatic step(input logic rst, input logic mrdy, input logic zero, input string tag,
                      input logic [3:0] exp_state, input logic [18:0] exp_vec);
    exp_t e;
    reset         = rst;
    u_if.MemReady = mrdy;
    u_if.Zero     = zero;
    e.tag   = tag;
    e.state = exp_state;
    e.vec   = exp_vec;
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq({e.tag, "_state"}, {28'd0, u_if.State}, {28'd0, e.state});
      check_eq({e.tag, "_ctl"}, {13'd0, w_obs}, {13'd0, e.vec});
    end
    @(posedge clk);
    #1;
  endtask

  logic [18:0] c_rst, c_fetch_rdy, c_fetch_wait, c_dec, c_ill, c_maddr, c_mread, c_mwb;
  logic [18:0] c_mwrite, c_rexec, c_rwb, c_iwb, c_br_t, c_br_n, c_jump, c_jal, c_jr;
  logic [18:0] c_rst_mwrite;
  logic [5:0]  i_ops  [4];
  logic [2:0]  i_alus [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    c_rst        = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 3'b110, 2'b00, 1'b0);
    c_fetch_rdy  = ov(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 3'b110, 2'b00, 1'b0);
    c_fetch_wait = ov(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 3'b110, 2'b00, 1'b0);
    c_dec        = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 3'b110, 2'b00, 1'b0);
    c_ill        = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 3'b110, 2'b00, 1'b1);
    c_maddr      = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 3'b010, 2'b00, 1'b0);
    c_mread      = ov(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0);
    c_mwb        = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0);
    c_mwrite     = ov(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0);
    c_rst_mwrite = ov(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0);
    c_rexec      = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 3'b111, 2'b00, 1'b0);
    c_rwb        = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0);
    c_iwb        = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0);
    c_br_t       = ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 3'b100, 2'b01, 1'b0);
    c_br_n       = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 3'b100, 2'b01, 1'b0);
    c_jump       = ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 2'b10, 1'b0);
    c_jal        = ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b1, 1'b0, 2'b00, 3'b000, 2'b10, 1'b0);
    c_jr         = ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'b111, 2'b11, 1'b0);
    i_ops[0] = 6'b001101; i_alus[0] = 3'b101;
    i_ops[1] = 6'b001100; i_alus[1] = 3'b011;
    i_ops[2] = 6'b001111; i_alus[2] = 3'b001;
    i_ops[3] = 6'b001000; i_alus[3] = 3'b110;

    reset         = 1'b1;
    u_if.Opcode   = 6'b000000;
    u_if.Funct    = 6'b100000;
    u_if.Zero     = 1'b0;
    u_if.MemReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Still in reset: FETCH selects visible, all enables forced low.
    step(1'b1, 1'b1, 1'b0, "reset", 4'd0, c_rst);

    // R-type add: 0,1,6,7
    u_if.Opcode = 6'b000000; u_if.Funct = 6'b100000;
    step(1'b0, 1'b1, 1'b0, "r_fetch", 4'd0, c_fetch_rdy);
    step(1'b0, 1'b1, 1'b0, "r_dec",   4'd1, c_dec);
    step(1'b0, 1'b1, 1'b0, "r_exec",  4'd6, c_rexec);
    step(1'b0, 1'b1, 1'b0, "r_wb",    4'd7, c_rwb);

    // LW with two wait cycles in MEM_READ: 0,1,2,3,3,3,4
    u_if.Opcode = 6'b100011;
    step(1'b0, 1'b1, 1'b0, "lw_fetch", 4'd0, c_fetch_rdy);
    step(1'b0, 1'b1, 1'b0, "lw_dec",   4'd1, c_dec);
    step(1'b0, 1'b1, 1'b0, "lw_addr",  4'd2, c_maddr);
    step(1'b0, 1'b0, 1'b0, "lw_rd0",   4'd3, c_mread);
    step(1'b0, 1'b0, 1'b0, "lw_rd1",   4'd3, c_mread);
    step(1'b0, 1'b1, 1'b0, "lw_rd2",   4'd3, c_mread);
    step(1'b0, 1'b1, 1'b0, "lw_wb",    4'd4, c_mwb);

    // BEQ / BNE with Zero = 1 and 0
    u_if.Opcode = 6'b000100;
    step(1'b0, 1'b1, 1'b0, "beq1_fetch", 4'd0, c_fetch_rdy);
    step(1'b0, 1'b1, 1'b0, "beq1_dec",   4'd1, c_dec);
    step(1'b0, 1'b1, 1'b1, "beq_z1",     4'd10, c_br_t);
    step(1'b0, 1'b1, 1'b0, "beq0_fetch", 4'd0, c_fetch_rdy);
    step(1'b0, 1'b1, 1'b0, "beq0_dec",   4'd1, c_dec);
    step(1'b0, 1'b1, 1'b0, "beq_z0",     4'd10, c_br_n);
    u_if.Opcode = 6'b000101;
    step(1'b0, 1'b1, 1'b0, "bne1_fetch", 4'd0, c_fetch_rdy);
    step(1'b0, 1'b1, 1'b0, "bne1_dec",   4'd1, c_dec);
    step(1'b0, 1'b1, 1'b1, "bne_z1",     4'd10, c_br_n);
    step(1'b0, 1'b1, 1'b0, "bne0_fetch", 4'd0, c_fetch_rdy);
    step(1'b0, 1'b1, 1'b0, "bne0_dec",   4'd1, c_dec);
    step(1'b0, 1'b1, 1'b0, "bne_z0",     4'd10, c_br_t);

    // I-type ALUOp selection; MemReady low in non-waiting states is ignored.
    for (int k = 0; k < 4; k++) begin
      u_if.Opcode = i_ops[k];
      step(1'b0, 1'b1, 1'b0, $sformatf("i%0d_fetch", k), 4'd0, c_fetch_rdy);
      step(1'b0, 1'b0, 1'b0, $sformatf("i%0d_dec", k),   4'd1, c_dec);
      step(1'b0, 1'b0, 1'b0, $sformatf("i%0d_exec", k),  4'd8,
           ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, i_alus[k], 2'b00, 1'b0));
      step(1'b0, 1'b0, 1'b0, $sformatf("i%0d_wb", k),    4'd9, c_iwb);
    end

    // SW with one FETCH wait cycle
    u_if.Opcode = 6'b101011;
    step(1'b0, 1'b0, 1'b0, "sw_fwait", 4'd0, c_fetch_wait);
    step(1'b0, 1'b1, 1'b0, "sw_fetch", 4'd0, c_fetch_rdy);
    step(1'b0, 1'b1, 1'b0, "sw_dec",   4'd1, c_dec);
    step(1'b0, 1'b1, 1'b0, "sw_addr",  4'd2, c_maddr);
    step(1'b0, 1'b1, 1'b0, "sw_wr",    4'd5, c_mwrite);

    // J, JAL, JR
    u_if.Opcode = 6'b000010;
    step(1'b0, 1'b1, 1'b0, "j_fetch",   4'd0, c_fetch_rdy);
    step(1'b0, 1'b1, 1'b0, "j_dec",     4'd1, c_dec);
    step(1'b0, 1'b1, 1'b0, "j_jump",    4'd11, c_jump);
    u_if.Opcode = 6'b000011;
    step(1'b0, 1'b1, 1'b0, "jal_fetch", 4'd0, c_fetch_rdy);
    step(1'b0, 1'b1, 1'b0, "jal_dec",   4'd1, c_dec);
    step(1'b0, 1'b1, 1'b0, "jal_exec",  4'd12, c_jal);
    u_if.Opcode = 6'b000000; u_if.Funct = 6'b001000;
    step(1'b0, 1'b1, 1'b0, "jr_fetch",  4'd0, c_fetch_rdy);
    step(1'b0, 1'b1, 1'b0, "jr_dec",    4'd1, c_dec);
    step(1'b0, 1'b1, 1'b0, "jr_exec",   4'd13, c_jr);

    // Illegal opcode: one-cycle pulse in DECODE, then FETCH
    u_if.Opcode = 6'b111111; u_if.Funct = 6'b100000;
    step(1'b0, 1'b1, 1'b0, "ill_fetch", 4'd0, c_fetch_rdy);
    step(1'b0, 1'b1, 1'b0, "ill_dec",   4'd1, c_ill);
    step(1'b0, 1'b0, 1'b0, "ill_back",  4'd0, c_fetch_wait);
    step(1'b0, 1'b1, 1'b0, "ill_next",  4'd0, c_fetch_rdy);

    // Reset asserted while SW waits in MEM_WRITE
    u_if.Opcode = 6'b101011;
    step(1'b0, 1'b1, 1'b0, "swr_dec",   4'd1, c_dec);
    step(1'b0, 1'b1, 1'b0, "swr_addr",  4'd2, c_maddr);
    step(1'b0, 1'b0, 1'b0, "swr_wait",  4'd5, c_mwrite);
    step(1'b1, 1'b0, 1'b0, "swr_rst",   4'd5, c_rst_mwrite);
    step(1'b0, 1'b1, 1'b0, "swr_after", 4'd0, c_fetch_rdy);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
